// File: rtl/reg_dump_tx.sv
// Register-file dump over UART: snapshots the 11 CPU registers and sends them as one
// 56-character ASCII hex line. Define REG_DUMP_PARITY_EN for 8E1 framing (default 8N1).
module reg_dump_tx #(
    parameter int CLK_DIV = 434
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [175:0] registersVGA,
    output logic         txd,
    output logic         busy,
    output logic         done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [5:0]    LAST_CHAR = 6'd55;
    localparam logic [5:0]    CR_CHAR   = 6'd54;
    localparam logic [2:0]    SPACE_POS = 3'd4;

`ifdef REG_DUMP_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } state_t;
`endif

    state_t         state_q,    state_d;
    logic [CW-1:0]  cnt_q,      cnt_d;
    logic [2:0]     bit_q,      bit_d;
    logic [5:0]     char_idx_q, char_idx_d;
    logic [2:0]     pos_q,      pos_d;
    logic [175:0]   snap_q,     snap_d;
    logic           txd_q,      txd_d;
    logic           busy_q,     busy_d;
    logic           done_q,     done_d;
    logic [7:0]     cur_char_s;
    logic           bit_end_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            hex_ascii = 8'h30 + wide;
        end else begin
            hex_ascii = 8'h37 + wide;
        end
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        even_parity = ^data;
    endfunction

    // Character currently on the line; the snapshot shifts left one nibble per hex digit sent.
    always_comb begin
        cur_char_s = 8'h00;
        if (char_idx_q == CR_CHAR) begin
            cur_char_s = 8'h0D;
        end else if (char_idx_q == LAST_CHAR) begin
            cur_char_s = 8'h0A;
        end else if (pos_q == SPACE_POS) begin
            cur_char_s = 8'h20;
        end else begin
            cur_char_s = hex_ascii(snap_q[175:172]);
        end
    end

    assign bit_end_s = (cnt_q == CNT_MAX);

    // Next-state and registered-output logic; txd_d reflects the bit of the state being entered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        char_idx_d = char_idx_q;
        pos_d      = pos_q;
        snap_d     = snap_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (start) begin
                    snap_d     = registersVGA;
                    char_idx_d = 6'd0;
                    pos_d      = 3'd0;
                    bit_d      = 3'd0;
                    state_d    = S_START;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    txd_d   = cur_char_s[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef REG_DUMP_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = even_parity(cur_char_s);
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = cur_char_s[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

`ifdef REG_DUMP_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif

            // The end of the stop bit also decides the next character (no idle gap).
            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (pos_q != SPACE_POS) begin
                        snap_d = {snap_q[171:0], 4'h0};
                        pos_d  = pos_q + 3'd1;
                    end else begin
                        pos_d  = 3'd0;
                    end
                    if (char_idx_q == LAST_CHAR) begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        char_idx_d = char_idx_q + 6'd1;
                        state_d    = S_START;
                        txd_d      = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            char_idx_q <= 6'd0;
            pos_q      <= 3'd0;
            snap_q     <= 176'd0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            char_idx_q <= char_idx_d;
            pos_q      <= pos_d;
            snap_q     <= snap_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/reg_dump_tx.md
# reg_dump_tx

- Serial debug transmitter for the 16-bit CPU's 176-bit register-file debug bus (`registersVGA`), on the consumer side.
- On a `start` request it snapshots all 11 registers (R0–R7, IH, SP, RA) and sends them over a UART TX line as one ASCII text line.
- Gives a board-level register dump alongside the VGA display, with no change to the register file.

## Interface
Parameters:
- `CLK_DIV`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is 2 or greater.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  reset; synchronous, active-high.
- `start`  input  1  dump request; sampled each rising edge.
- `registersVGA`  input  176  register bus; R0 in [175:160], R1 in [159:144], … RA in [15:0].
- `txd`  output  1  UART serial data; idles high.
- `busy`  output  1  a dump is in progress.
- `done`  output  1  one-cycle pulse when a dump completes.

## Operation
- States: IDLE, START, DATA, STOP, NEXT. PARITY is added only under the configuration macro.
- **IDLE**
  - `txd`=1, `busy`=0.
  - `start`=1 at an edge: latch `registersVGA` into a 176-bit snapshot, clear the char index to 0, go to START.
  - `start` is ignored while `busy`=1; requests are not queued.
- **Line format:** 56 characters, index 0..55.
  - For each register Rk (k=0..10), 4 uppercase hex digits, MS nibble first.
  - A space (0x20) after each of R0..SP.
  - After RA: CR (0x0D), then LF (0x0A).
- **Hex mapping:** nibble 0–9 maps to 0x30+n; nibble A–F maps to 0x41+(n−10).
- **Character frame (8N1)**
  - START: `txd`=0.
  - DATA: 8 bits, LSB first.
  - STOP: `txd`=1.
  - Each bit is held exactly `CLK_DIV` cycles. The baud counter is $clog2(CLK_DIV) bits wide and counts 0..CLK_DIV−1.
- **NEXT** (zero-width, decided in the same edge that ends STOP)
  - Index < 55: increment the index and start the next character's start bit immediately; there are no idle gaps between characters.
  - Index = 55: return to IDLE.
- The character source is the snapshot only. Changes on `registersVGA` during a dump have no effect.
- **Reset**
  - Outputs after reset: `txd`=1, `busy`=0, `done`=0; state IDLE; counters 0.
  - `rst` has priority over `start` in the same edge.
  - `rst` mid-dump aborts the dump at once: `txd`=1 on the next cycle, and no `done` pulse.

## Timing
- **Start of a dump:** `start` seen at edge k. From k+1, `busy`=1 and `txd`=0 (start bit).
- **Length of a dump:** the line takes 56 × 10 × CLK_DIV cycles, counted from edge k+1. That is 2240 cycles at CLK_DIV=4, or 11 × CLK_DIV per character with parity.
- **End of a dump:**
  - In the cycle after the last stop bit's final cycle, `done`=1 for exactly one cycle and `busy`=0 in that same cycle.
  - A `start` in that cycle is accepted and begins a new dump.
- **Output quality:** `txd` is driven from a register, so it has no combinational glitches.
- **Bit timing accuracy:** all bit periods are exact. There is no cumulative drift across the line.

## Configuration
- `REG_DUMP_PARITY_EN`
  - Defined: frame is 8E1. A PARITY state sits between DATA and STOP and sends the XOR of the 8 data bits for `CLK_DIV` cycles. Frame is 11 bits; the line takes 56 × 11 × CLK_DIV cycles.
  - Undefined: 8N1 as described above. No PARITY state, no parity logic.

## Test plan
All scenarios use CLK_DIV=4.
- **Reset values:** assert `rst` 3 cycles → `txd`=1, `busy`=0, `done`=0. Repeat with `start`=1 held during `rst` → still idle afterwards.
- **Basic line:** R0=0x1234, all others 0, pulse `start`.
  - First frame on `txd`: 0, then 1,0,0,0,1,1,0,0 (0x31), then 1; each bit 4 cycles.
  - Decoded line: "1234 0000 0000 0000 0000 0000 0000 0000 0000 0000 0000\r\n".
  - `done` pulses exactly 2240 cycles after the first `busy` cycle.
- **Hex mapping and ordering:** SP=0x00F9, RA=0xABCD → line ends "00F9 ABCD\r\n", uppercase, CR before LF.
- **Snapshot and busy handling:**
  - Change `registersVGA` and pulse `start` again mid-dump → output matches the value at the original start edge; only one line is sent; only one `done`.
  - `start` held high through `done` → a second line begins immediately.
- **Reset mid-dump:** assert `rst` during a data bit of character 20 → `txd`=1 and `busy`=0 next cycle, and `done` never pulses. A following `start` yields a complete, correct 56-character line.
- **Parity (`REG_DUMP_PARITY_EN`):** character '1' (0x31, three ones) → parity bit 1; space (0x20) → parity bit 1; '0' (0x30) → parity bit 0. `done` arrives 2464 cycles after start.
